// File: rtl/ipv4_ttl_rewriter.sv
// ipv4_ttl_rewriter
//   Header-edit stage in front of the incremental checksum unit. Captures one
//   HDR_WORDS x 16-bit IPv4 header, decrements TTL, asks the checksum unit for
//   the patched checksum, and then replays the header with the TTL/protocol
//   word and the checksum word replaced. Headers that arrive with TTL 0 or 1
//   are forwarded untouched and flagged on out_expired.
//
// Ports
//   clk, reset                        : clock, async active-high reset
//   in_valid/in_ready/in_data/in_last : header word input stream
//   out_valid/out_ready/out_data/out_last, out_expired : rewritten header out
//   cs_req, cs_old_checksum, cs_removed_val, cs_new_val : request to csum unit
//   cs_gnt, cs_new_checksum           : csum unit reply
//   err_cnt                           : saturating malformed-header count
module ipv4_ttl_rewriter #(
    parameter int TTL_IDX   = 4,
    parameter int CSUM_IDX  = 5,
    parameter int HDR_WORDS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        out_expired,
    output logic        cs_req,
    output logic [15:0] cs_old_checksum,
    output logic [15:0] cs_removed_val,
    output logic [15:0] cs_new_val,
    input  logic        cs_gnt,
    input  logic [15:0] cs_new_checksum,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(HDR_WORDS - 1);

    localparam logic [2:0] S_CAPTURE = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    logic [2:0]  state;
    logic [15:0] hdr_buf [HDR_WORDS];
    logic [3:0]  wr_idx;
    logic [3:0]  rd_idx;
    logic        expired;

    logic [7:0]  ttl;
    logic        ttl_dead;
    logic        in_fire;
    logic        hdr_done;
    logic        err_inc;

    assign in_ready    = (state == S_CAPTURE) || (state == S_DRAIN);
    assign out_valid   = (state == S_EMIT);
    assign out_data    = hdr_buf[rd_idx];
    assign out_last    = out_valid && (rd_idx == LAST_IDX);
    assign out_expired = expired;
    assign cs_req      = (state == S_REQ);

    assign in_fire  = in_valid && in_ready;
    assign ttl      = hdr_buf[TTL_IDX][15:8];
    assign ttl_dead = (ttl <= 8'd1);

    // A header is complete either on a well-formed final word, or when the
    // tail of an over-long header finally shows in_last. TTL/CSUM words sit
    // below the last index, so they are already in the buffer at this point.
    assign hdr_done = in_fire && in_last &&
                      (((state == S_CAPTURE) && (wr_idx == LAST_IDX)) ||
                       (state == S_DRAIN));

    // Malformed: in_last too early, or missing on the final buffered word.
    assign err_inc  = in_fire && (state == S_CAPTURE) &&
                      ((wr_idx == LAST_IDX) ? !in_last : in_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_CAPTURE;
            wr_idx          <= '0;
            rd_idx          <= '0;
            expired         <= 1'b0;
            cs_old_checksum <= '0;
            cs_removed_val  <= '0;
            cs_new_val      <= '0;
            err_cnt         <= '0;
            for (int i = 0; i < HDR_WORDS; i++) hdr_buf[i] <= '0;
        end else begin
            case (state)
                S_CAPTURE: begin
                    if (in_fire) begin
                        hdr_buf[wr_idx] <= in_data;
                        if (wr_idx == LAST_IDX) begin
                            if (!in_last) state <= S_DRAIN;
                        end else if (in_last) begin
                            wr_idx <= '0;          // short header: discard
                        end else begin
                            wr_idx <= wr_idx + 4'd1;
                        end
                    end
                end
                S_DRAIN: ;                         // exits via hdr_done below
                S_REQ:   state <= S_WAIT;
                S_WAIT: begin
                    if (cs_gnt) begin
                        hdr_buf[CSUM_IDX] <= cs_new_checksum;
                        hdr_buf[TTL_IDX]  <= cs_new_val;
                        state             <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx  <= '0;
                            wr_idx  <= '0;
                            expired <= 1'b0;
                            state   <= S_CAPTURE;
                        end else begin
                            rd_idx <= rd_idx + 4'd1;
                        end
                    end
                end
                default: state <= S_CAPTURE;
            endcase

            if (hdr_done) begin
                if (ttl_dead) begin
                    expired <= 1'b1;
                    state   <= S_EMIT;
                end else begin
                    // Operands held from here until the grant; the buffer is
                    // not touched again before then.
                    cs_old_checksum <= hdr_buf[CSUM_IDX];
                    cs_removed_val  <= hdr_buf[TTL_IDX];
                    cs_new_val      <= {ttl - 8'd1, hdr_buf[TTL_IDX][7:0]};
                    state           <= S_REQ;
                end
            end

            if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ipv4_ttl_rewriter.sv
// Self-checking bench for ipv4_ttl_rewriter: directed test-plan steps plus
// randomized headers, checked against a header-level reference model.
module tb_ipv4_ttl_rewriter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_expired;
    logic        cs_req;
    logic [15:0] cs_old_checksum;
    logic [15:0] cs_removed_val;
    logic [15:0] cs_new_val;
    logic        cs_gnt = 1'b0;
    logic [15:0] cs_new_checksum = '0;
    logic [7:0]  err_cnt;

    int passed = 0;
    int total = 0;
    int req_seen = 0;
    int err_model = 0;

    always #5 clk = ~clk;

    ipv4_ttl_rewriter dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_expired(out_expired),
        .cs_req(cs_req), .cs_old_checksum(cs_old_checksum),
        .cs_removed_val(cs_removed_val), .cs_new_val(cs_new_val),
        .cs_gnt(cs_gnt), .cs_new_checksum(cs_new_checksum),
        .err_cnt(err_cnt)
    );

    always @(posedge clk) if (cs_req) req_seen <= req_seen + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Ones'-complement incremental update HC' = ~(~HC + ~m + m').
    function automatic logic [15:0] csum_upd(input logic [15:0] hc, input logic [15:0] m,
                                             input logic [15:0] mn);
        logic [15:0] a, b;
        int s;
        a = ~hc;
        b = ~m;
        s = int'(a) + int'(b) + int'(mn);
        s = (s & 32'hFFFF) + (s >>> 16);
        s = (s & 32'hFFFF) + (s >>> 16);
        return ~16'(s);
    endfunction

    task automatic bump_err();
        if (err_model < 255) err_model++;
    endtask

    task automatic send_hdr(input logic [15:0] w[$], input bit gaps);
        for (int i = 0; i < w.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = (i == w.size() - 1);
            chk("in_ready", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Checksum-unit stand-in: grant 3 cycles after the request (plus extra).
    task automatic respond(input logic [15:0] val, input logic [15:0] o_cs,
                           input logic [15:0] o_rm, input logic [15:0] o_nv, input int extra);
        for (int i = 0; i < 2 + extra; i++) begin
            @(negedge clk);
            chk("req_one_cycle", cs_req, 0);
            chk("op_hold_old", cs_old_checksum, o_cs);
            chk("op_hold_new", cs_new_val, o_nv);
            chk("op_hold_rm", cs_removed_val, o_rm);
        end
        cs_gnt = 1'b1;
        cs_new_checksum = val;
        @(negedge clk);
        cs_gnt = 1'b0;
        cs_new_checksum = 16'($urandom);
    endtask

    // mode 0: ready held high, 1: toggling, 2: random
    task automatic collect(input logic [15:0] exp[10], input bit exp_x, input int mode);
        int idx = 0;
        int cyc = 0;
        bit r;
        chk("first_valid", out_valid, 1);
        while (idx < 10 && cyc < 300) begin
            if (out_valid) begin
                chk("out_data", out_data, exp[idx]);
                chk("out_last", out_last, (idx == 9));
                chk("out_expired", out_expired, exp_x);
            end else if (mode == 0) begin
                chk("valid_gap", out_valid, 1);
            end
            r = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            out_ready = r;
            if (out_valid && r) idx++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("emit_count", idx, 10);
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_expired", out_expired, 0);
    endtask

    task automatic run(input logic [15:0] w[$], input int mode, input bit gaps);
        logic [15:0] h[10];
        logic [7:0]  ttl;
        logic [15:0] nv, nc;
        int r0;
        r0 = req_seen;
        send_hdr(w, gaps);
        if (w.size() < 10) begin
            bump_err();
            repeat (3) begin
                chk("short_no_out", out_valid, 0);
                @(negedge clk);
            end
            chk("short_no_req", req_seen - r0, 0);
            chk("short_err", err_cnt, err_model);
            chk("short_in_ready", in_ready, 1);
            return;
        end
        if (w.size() > 10) bump_err();
        for (int i = 0; i < 10; i++) h[i] = w[i];
        chk("err_cnt", err_cnt, err_model);
        ttl = h[4][15:8];
        if (ttl <= 8'd1) begin
            chk("exp_no_req", cs_req, 0);
            collect(h, 1'b1, mode);
            chk("exp_req_cnt", req_seen - r0, 0);
        end else begin
            nv = {ttl - 8'd1, h[4][7:0]};
            chk("cs_req", cs_req, 1);
            chk("op_old", cs_old_checksum, h[5]);
            chk("op_rm", cs_removed_val, h[4]);
            chk("op_new", cs_new_val, nv);
            nc = csum_upd(h[5], h[4], nv);
            respond(nc, h[5], h[4], nv, (mode == 2) ? $urandom_range(0, 4) : 0);
            h[4] = nv;
            h[5] = nc;
            collect(h, 1'b0, mode);
            chk("req_cnt", req_seen - r0, 1);
        end
    endtask

    initial begin
        logic [15:0] nom[$];
        logic [15:0] q[$];
        int n;
        int kind;
        nom = {16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
               16'hB861, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cs_req", cs_req, 0);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_expired", out_expired, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_op_old", cs_old_checksum, 0);
        chk("rst_op_rm", cs_removed_val, 0);
        chk("rst_op_new", cs_new_val, 0);

        // nominal, expired (TTL 1 and 0), backpressure
        run(nom, 0, 0);
        q = nom; q[4] = 16'h0111; run(q, 0, 0);
        q = nom; q[4] = 16'h0011; run(q, 0, 0);
        run(nom, 1, 0);

        // short header (last on word 6), then a normal one
        q = {};
        for (int i = 0; i < 7; i++) q.push_back(nom[i]);
        run(q, 0, 0);
        run(nom, 0, 0);

        // long header: 12 words
        q = nom; q.push_back(16'hDEAD); q.push_back(16'hBEEF);
        run(q, 0, 0);

        // reset during WAIT, then a stray grant
        send_hdr(nom, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        err_model = 0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_req", cs_req, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_err", err_cnt, 0);
        chk("mid_rst_op_old", cs_old_checksum, 0);
        cs_gnt = 1'b1;
        cs_new_checksum = 16'h1234;
        @(negedge clk);
        cs_gnt = 1'b0;
        @(negedge clk);
        chk("stray_valid", out_valid, 0);
        chk("stray_in_ready", in_ready, 1);
        chk("stray_req", cs_req, 0);
        run(nom, 0, 0);

        // randomized headers
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 7);
            n = (kind == 6) ? $urandom_range(1, 9) : (kind == 7) ? $urandom_range(11, 14) : 10;
            q = {};
            for (int i = 0; i < n; i++) q.push_back(16'($urandom));
            if (n > 4) begin
                case ($urandom_range(0, 4))
                    0: q[4][15:8] = 8'd0;
                    1: q[4][15:8] = 8'd1;
                    2: q[4][15:8] = 8'd2;
                    3: q[4][15:8] = 8'd255;
                    default: ;
                endcase
            end
            run(q, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // err_cnt saturation: 260 one-word malformed headers
        in_valid = 1'b1;
        in_last  = 1'b1;
        repeat (260) begin
            in_data = 16'($urandom);
            bump_err();
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("err_sat", err_cnt, 8'd255);
        chk("err_sat_model", err_cnt, err_model);
        chk("err_sat_no_out", out_valid, 0);
        run(nom, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
